ibuf_offset_cal: RTL and testbench

Sequencer that calibrates the input-offset trim of a differential I/O buffer (the `OSC[3:0]` / `OSC_EN[1:0]` trim inputs) for the DDR3 DQS/DQ pads. On `start` it puts the buffer in offset-calibration mode and sweeps the 15 trim values from most negative to most positive. At each value it samples the buffer output and finds the first value where the output flips to 1. It then latches that code and drives it statically with calibration mode off. One instance per calibrated buffer, in the PHY init path before read leveling.

---
 rtl/ibuf_offset_cal.sv | 196 +++++++++++++++++++
 tb/tb_ibuf_offset_cal.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_offset_cal.sv
// Input-offset trim calibration sequencer for a differential I/O buffer.
// Optional feature macro: IBUF_CAL_TWO_PASS_EN (adds a centering down-sweep).
module ibuf_offset_cal #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ibuf_o,
  output logic [3:0] osc,
  output logic [1:0] osc_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] cal_code
);

  localparam int CW = $clog2(SAMPLES) + 1;
  localparam int NW = $clog2(SAMPLES);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, EVAL, FINISH} state_t;

  state_t          r_state;
  logic [3:0]      r_idx;
  logic [SW-1:0]   r_settle;
  logic [NW-1:0]   r_samp;
  logic [CW-1:0]   r_ones;
  logic [3:0]      r_osc;
  logic [1:0]      r_oscEn;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [3:0]      r_calCode;
`ifdef IBUF_CAL_TWO_PASS_EN
  logic            r_down;
  logic [3:0]      r_edge;
  logic            w_nextDown;
  logic [4:0]      w_centerSum;
`endif

  logic            w_hit;
  logic            w_major;
  logic            w_finish;
  logic            w_ok;
  logic [3:0]      w_resIdx;
  logic [3:0]      w_nextIdx;
  logic [3:0]      w_resCode;

  // Step index 0..14 -> sign/magnitude trim, most negative first.
  function automatic logic [3:0] codeOf(input logic [3:0] i);
    if (i < 4'd7)       codeOf = {1'b0, 3'(4'd7 - i)};
    else if (i == 4'd7) codeOf = 4'b0000;
    else                codeOf = {1'b1, 3'(i - 4'd7)};
  endfunction

  assign w_hit   = (ibuf_o === 1'b1);
  assign w_major = (r_ones > CW'(SAMPLES / 2));

  always_comb begin
    w_finish  = 1'b0;
    w_ok      = 1'b0;
    w_resIdx  = 4'd0;
    w_nextIdx = r_idx;
`ifdef IBUF_CAL_TWO_PASS_EN
    w_nextDown  = r_down;
    w_centerSum = ({1'b0, r_edge} + {1'b0, r_idx} + 5'd1) >> 1;
    if (!r_down) begin
      if (w_major) begin
        if (r_idx == 4'd0) begin
          w_finish = 1'b1;
        end else begin
          w_nextDown = 1'b1;
          w_nextIdx  = 4'd14;
        end
      end else if (r_idx == 4'd14) begin
        w_finish = 1'b1;
      end else begin
        w_nextIdx = r_idx + 4'd1;
      end
    end else begin
      if (!w_major) begin
        w_finish = 1'b1;
        if (r_idx < r_edge) begin
          w_ok     = 1'b1;
          w_resIdx = w_centerSum[3:0];
        end
      end else if (r_idx == 4'd0) begin
        w_finish = 1'b1;
      end else begin
        w_nextIdx = r_idx - 4'd1;
      end
    end
`else
    if (w_major) begin
      w_finish = 1'b1;
      w_ok     = (r_idx != 4'd0);
      w_resIdx = r_idx;
    end else if (r_idx == 4'd14) begin
      w_finish = 1'b1;
    end else begin
      w_nextIdx = r_idx + 4'd1;
    end
`endif
    w_resCode = w_ok ? codeOf(w_resIdx) : 4'b0000;
  end

  // Outputs are loaded on state entry so they are valid in the state's first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= 4'd0;
      r_settle  <= '0;
      r_samp    <= '0;
      r_ones    <= '0;
      r_osc     <= 4'b0000;
      r_oscEn   <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_calCode <= 4'b0000;
`ifdef IBUF_CAL_TWO_PASS_EN
      r_down    <= 1'b0;
      r_edge    <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= APPLY;
            r_idx   <= 4'd0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_osc   <= codeOf(4'd0);
            r_oscEn <= 2'b11;
`ifdef IBUF_CAL_TWO_PASS_EN
            r_down  <= 1'b0;
`endif
          end
        end
        APPLY: begin
          r_settle <= SW'(SETTLE_CYCLES - 1);
          r_state  <= SETTLE;
        end
        SETTLE: begin
          if (r_settle == '0) begin
            r_state <= SAMPLE;
            r_samp  <= NW'(SAMPLES - 1);
            r_ones  <= '0;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        SAMPLE: begin
          r_ones <= r_ones + CW'(w_hit);
          if (r_samp == '0) r_state <= EVAL;
          else              r_samp  <= r_samp - 1'b1;
        end
        EVAL: begin
          if (w_finish) begin
            r_state   <= FINISH;
            r_calCode <= w_resCode;
            r_err     <= ~w_ok;
            r_osc     <= w_resCode;
            r_oscEn   <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state <= APPLY;
            r_idx   <= w_nextIdx;
            r_osc   <= codeOf(w_nextIdx);
`ifdef IBUF_CAL_TWO_PASS_EN
            if (!r_down && w_nextDown) r_edge <= r_idx;
            r_down <= w_nextDown;
`endif
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign osc      = r_osc;
  assign osc_en   = r_oscEn;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign cal_code = r_calCode;

endmodule

// File: tb/tb_ibuf_offset_cal.sv
// Scoreboard bench for ibuf_offset_cal: a buffer model with a configurable
// intrinsic offset, a reference predictor, and a negedge monitor.
module tb_ibuf_offset_cal;

  localparam int SETTLE = 8;
  localparam int SAMP   = 16;
  localparam int P      = SETTLE + SAMP + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ibuf_o;
  logic [3:0] osc;
  logic [1:0] osc_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cal_code;

  int   cyc = 0;
  int   intrinsic = 0;
  logic toggle = 1'b0;

  typedef struct {
    int         startCyc;
    int         doneCyc;
    int         upSteps;
    logic [3:0] code;
    logic       err;
  } exp_t;

  exp_t q[$];

  int         nComp = 0;
  int         nFail = 0;
  int         rstLow = 0;
  logic [3:0] lastCode = 4'h0;
  logic       lastErr = 1'b0;
  int         k;
  int         stepIdx;

  ibuf_offset_cal #(.SETTLE_CYCLES(SETTLE), .SAMPLES(SAMP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ibuf_o(ibuf_o),
    .osc(osc), .osc_en(osc_en), .busy(busy), .done(done),
    .err(err), .cal_code(cal_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    toggle <= ~toggle;
  end

  // Buffer: O=1 when intrinsic+trim>0, toggles at exactly zero, 0 when not in cal mode.
  function automatic logic bufModel(input int intr, input logic [3:0] c,
                                    input logic [1:0] en, input logic tg);
    int trim;
    int sum;
    trim = c[3] ? 5 * int'(c[2:0]) : -5 * int'(c[2:0]);
    sum  = intr + trim;
    if (en != 2'b11) return 1'b0;
    if (sum > 0)     return 1'b1;
    if (sum == 0)    return tg;
    return 1'b0;
  endfunction

  assign ibuf_o = bufModel(intrinsic, osc, osc_en, toggle);

  function automatic logic [3:0] codeFor(input int idx);
    int mag;
    mag = (idx > 7) ? idx - 7 : 7 - idx;
    return {(idx > 7) ? 1'b1 : 1'b0, 3'(mag)};
  endfunction

  function automatic int offsetMv(input int idx);
    return 5 * (idx - 7);
  endfunction

  function automatic exp_t predict(input int intr, input int c);
    exp_t p;
    int   e;
    int   idx;
    int   steps;
    logic ok;
    e = -1;
    for (int i = 0; i < 15; i++)
      if (e < 0 && intr + offsetMv(i) > 0) e = i;
    p.startCyc = c;
    p.upSteps  = (e < 0) ? 15 : e + 1;
    steps      = p.upSteps;
    ok         = (e > 0);
    idx        = e;
`ifdef IBUF_CAL_TWO_PASS_EN
    if (e > 0) begin
      int d;
      d = -1;
      for (int i = 14; i >= 0; i--)
        if (d < 0 && intr + offsetMv(i) <= 0) d = i;
      steps = steps + ((d < 0) ? 15 : 15 - d);
      ok    = (d >= 0) && (d < e);
      idx   = (e + d + 1) >> 1;
    end
`endif
    p.code    = ok ? codeFor(idx) : 4'h0;
    p.err     = ~ok;
    p.doneCyc = c + 1 + steps * P;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    nComp++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      lastCode = 4'h0;
      lastErr  = 1'b0;
      rstLow++;
      if (rstLow >= 2) begin
        checkOutput("rstOsc",     8'(osc),      8'h00);
        checkOutput("rstOscEn",   8'(osc_en),   8'h00);
        checkOutput("rstBusy",    8'(busy),     8'h00);
        checkOutput("rstDone",    8'(done),     8'h00);
        checkOutput("rstErr",     8'(err),      8'h00);
        checkOutput("rstCalCode", 8'(cal_code), 8'h00);
      end
    end else begin
      rstLow = 0;
      if (q.size() > 0 && cyc > q[0].startCyc && cyc < q[0].doneCyc) begin
        k       = (cyc - q[0].startCyc - 1) / P;
        stepIdx = (k < q[0].upSteps) ? k : 14 - (k - q[0].upSteps);
        checkOutput("sweepBusy",  8'(busy),   8'h01);
        checkOutput("sweepOscEn", 8'(osc_en), 8'h03);
        checkOutput("sweepOsc",   8'(osc),    8'(codeFor(stepIdx)));
        checkOutput("sweepDone",  8'(done),   8'h00);
        checkOutput("sweepErr",   8'(err),    8'h00);
      end else if (q.size() > 0 && cyc == q[0].doneCyc) begin
        checkOutput("donePulse", 8'(done),     8'h01);
        checkOutput("doneCode",  8'(cal_code), 8'(q[0].code));
        checkOutput("doneErr",   8'(err),      8'(q[0].err));
        checkOutput("doneBusy",  8'(busy),     8'h00);
        checkOutput("doneOscEn", 8'(osc_en),   8'h00);
        checkOutput("doneOsc",   8'(osc),      8'(q[0].code));
        lastCode = q[0].code;
        lastErr  = q[0].err;
        void'(q.pop_front());
      end else begin
        checkOutput("idleDone",    8'(done),     8'h00);
        checkOutput("idleBusy",    8'(busy),     8'h00);
        checkOutput("idleOscEn",   8'(osc_en),   8'h00);
        checkOutput("idleOsc",     8'(osc),      8'(lastCode));
        checkOutput("idleCalCode", 8'(cal_code), 8'(lastCode));
        checkOutput("idleErr",     8'(err),      8'(lastErr));
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int intr, input int ignoreAt, input int resetAt);
    int c0;
    int budget;
    stepCycle();
    intrinsic = intr;
    start     = 1'b1;
    c0        = cyc;
    q.push_back(predict(intr, c0));
    stepCycle();
    start = 1'b0;
    if (ignoreAt > 0) begin
      while (cyc < c0 + ignoreAt) stepCycle();
      start = 1'b1;
      stepCycle();
      start = 1'b0;
    end
    if (resetAt > 0) begin
      while (cyc < c0 + resetAt) stepCycle();
      rst_n = 1'b0;
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      return;
    end
    budget = 0;
    while (q.size() > 0 && budget < 3000) begin
      stepCycle();
      budget++;
    end
    if (q.size() > 0) begin
      $display("[TB] FAIL doneTimeout: intrinsic %0d, no done within %0d cycles", intr, budget);
      $fatal(1, "[TB] timeout");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) stepCycle();
    rst_n = 1'b1;
    repeat (2) stepCycle();

    applyStimulus(12, 0, 0);
    applyStimulus(12, 50, 0);
    applyStimulus(-12, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(40, 0, 0);
    applyStimulus(-40, 0, 0);
    applyStimulus(12, 0, 60);
    applyStimulus(12, 0, 0);
    for (int n = 0; n < 8; n++)
      applyStimulus(int'($urandom_range(90, 0)) - 45, 0, 0);

    repeat (4) stepCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
